// File: rtl/nco_dac_serializer.sv
// Sample FIFO feeding a 16-bit SPI-style frame serializer for a 12-bit DAC.
// Generates SCLK/CSn/SDO, tracks occupancy and flags dropped samples.
module nco_dac_serializer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DIV   = 2,
    parameter int unsigned GAP   = 3,
    parameter logic [3:0]  CMD   = 4'b0011
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     En,
    input  logic                     Vld,
    input  logic [11:0]              Din,
    input  logic                     Clr,
    output logic                     SCLK,
    output logic                     CSn,
    output logic                     SDO,
    output logic                     Busy,
    output logic                     Ovf,
    output logic [$clog2(DEPTH):0]   Level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = $clog2(DIV + 1);
    localparam int unsigned GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [11:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [LW-1:0]  r_level;
    logic           r_ovf;
    logic [15:0]    r_sr;
    logic [3:0]     r_bit;
    logic [DW-1:0]  r_div;
    logic [GW-1:0]  r_gap;
    logic           r_sclk;
    logic           r_csn;
    logic           r_sdo;
    logic           r_busy;

    logic [15:0]    w_sr_nxt;
    logic [3:0]     w_bit_nxt;
    logic [DW-1:0]  w_div_nxt;
    logic [GW-1:0]  w_gap_nxt;
    logic           w_sclk_nxt;
    logic           w_csn_nxt;
    logic           w_sdo_nxt;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;

    // A push into a full FIFO is still accepted when the head pops this cycle
    assign w_full = (r_level == LW'(DEPTH));
    assign w_pop  = (r_state == S_IDLE) && (r_level != '0);
    assign w_push = En && Vld && (!w_full || w_pop);
    assign w_drop = En && Vld && w_full && !w_pop;

    // Frame sequencing: SCLK toggles every DIV cycles, SDO advances on falling edges
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bit_nxt   = r_bit;
        w_div_nxt   = r_div;
        w_gap_nxt   = r_gap;
        w_sclk_nxt  = r_sclk;
        w_csn_nxt   = r_csn;
        w_sdo_nxt   = r_sdo;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_sr_nxt    = {CMD, r_mem[r_rptr]};
                    w_bit_nxt   = 4'd15;
                    w_div_nxt   = '0;
                    w_sclk_nxt  = 1'b0;
                    w_csn_nxt   = 1'b0;
                    w_sdo_nxt   = CMD[3];
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_div == DW'(DIV - 1)) begin
                    w_div_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit == 4'd0) begin
                            w_csn_nxt   = 1'b1;
                            w_sdo_nxt   = 1'b0;
                            w_gap_nxt   = '0;
                            w_state_nxt = S_GAP;
                        end else begin
                            w_bit_nxt = r_bit - 4'd1;
                            w_sr_nxt  = {r_sr[14:0], 1'b0};
                            w_sdo_nxt = r_sr[14];
                        end
                    end
                end else begin
                    w_div_nxt = r_div + DW'(1);
                end
            end
            S_GAP: begin
                if (r_gap == GW'(GAP - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + GW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_gap   <= '0;
            r_sclk  <= 1'b0;
            r_csn   <= 1'b1;
            r_sdo   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_bit   <= w_bit_nxt;
            r_div   <= w_div_nxt;
            r_gap   <= w_gap_nxt;
            r_sclk  <= w_sclk_nxt;
            r_csn   <= w_csn_nxt;
            r_sdo   <= w_sdo_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // FIFO bookkeeping and sticky overflow (a new drop beats Clr)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (Clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= Din;
        end
    end

    assign SCLK  = r_sclk;
    assign CSn   = r_csn;
    assign SDO   = r_sdo;
    assign Busy  = r_busy;
    assign Ovf   = r_ovf;
    assign Level = r_level;

endmodule

// File: doc/nco_dac_serializer.md
Name: nco_dac_serializer

Overview:
Downstream consumer of the NCO output terminal. It accepts 12-bit samples (Dout/Vld) into a small FIFO and shifts each one out to an external 12-bit serial DAC as a 16-bit SPI-style frame (4-bit command + 12-bit data, MSB first). It also generates the DAC clock, chip select, and an overflow flag for dropped samples.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
DIV, 2, clk cycles per SCLK half-period; at least 1
GAP, 3, minimum clk cycles CSn stays high between frames, on top of the fixed 1 IDLE cycle; at least 1
CMD, 4'b0011, command nibble sent in frame bits [15:12]

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
En  input  1  sample accept enable
Vld  input  1  Din valid, from output terminal
Din  input  12  sample, from output terminal Dout
Clr  input  1  synchronous clear of Ovf
SCLK  output  1  DAC serial clock; idles low
CSn  output  1  DAC chip select, active low
SDO  output  1  serial data
Busy  output  1  high when FSM is not in IDLE
Ovf  output  1  sticky flag: a sample was dropped
Level  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - SCLK=0, CSn=1, SDO=0, Busy=0, Ovf=0, Level=0.
  - FIFO pointers cleared; FSM goes to IDLE; divider and bit counters cleared.
  - Asserting reset mid-frame aborts the frame immediately (CSn goes high asynchronously).
- FIFO push: occurs when En & Vld & (!full | pop_this_cycle).
- FIFO drop: when En & Vld & full & !pop, the sample is discarded and Ovf is set on the next edge.
- Ovf clear: Clr=1 clears Ovf. If Clr and a new drop occur in the same cycle, the set wins.
- Level: updated every edge: +1 on push only, -1 on pop only, unchanged on push and pop together.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If FIFO is non-empty: pop; load shift register with {CMD, head}; load bit counter = 15; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Let T be the first SHIFT cycle. From T: CSn=0, SDO=frame bit 15, SCLK=0.
  - Frame bit (15-k), for k=0..15:
    - SDO valid from T+2kDIV.
    - SCLK high during [T+(2k+1)DIV, T+(2k+2)DIV-1]; the DAC samples on the rising edge.
  - SDO updates only on the SCLK falling edge.
  - At T+32DIV: SCLK=0, CSn=1, SDO=0; go to GAP.
- GAP:
  - Stay GAP cycles, then go to IDLE.
  - Minimum CSn-high time is GAP+1 cycles.
  - Frame period with back-to-back data is 32DIV+GAP+1 clk (68 with defaults).
- En=0: suppresses pushes only. A frame in progress and the queued samples still drain.
- Pointers wrap modulo DEPTH; full means Level==DEPTH.
- Din is never modified; the data is the raw 12 bits.

Test Plan:
- Single sample Vld=1, Din=12'hABC, defaults:
  - CSn low for exactly 64 cycles.
  - SDO bits on SCLK rising edges are 0011_1010_1011_1100.
  - 16 SCLK pulses, each 2 cycles high; Busy high until GAP ends; Level returns to 0.
- Back-to-back: push 12'h000, 12'hFFF, 12'h800 on consecutive cycles:
  - Three frames with CSn-high spacing of exactly 4 cycles.
  - Data order preserved; Level peaks at 2 (the first sample pops immediately).
- Overflow: push 6 samples on consecutive cycles:
  - The first 5 are accepted (1 popped immediately, 4 queued) and sent in order; the 6th is dropped; Ovf=1.
  - Pulse Clr: Ovf=0.
  - Clr in the same cycle as a new drop: Ovf stays 1.
- Full with simultaneous pop: fill the FIFO while the FSM is in GAP, then push a sample on the IDLE pop cycle:
  - Push accepted, Level stays 4, Ovf stays 0.
- Reset mid-frame: assert rst_n=0 at bit 7:
  - CSn=1, SCLK=0, SDO=0 immediately; Level=0.
  - After release, no residual frame is sent.
- En=0 with Vld=1 for 20 cycles: no frames, Level=0, Ovf=0.
